// File: rtl/bc_display_pkg.sv
// bc_display_pkg: display modes, character codes and active-low segment patterns for the scanner.
package bc_display_pkg;
  typedef enum logic [1:0] {ENTRY, RESULT, WIN, BLANK} mode_t;
  typedef enum logic [4:0] {
    CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7,
    CH_8, CH_9, CH_A, CH_B, CH_C, CH_D, CH_E_HEX, CH_F,
    CH_BL, CH_CU, CH_P, CH_DL, CH_O, CH_N, CH_E, CH_DASH, CH_BLANK
  } char_t;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Counts above 4 cannot occur in a legal game and are flagged with a dash.
  function automatic char_t count_char(input logic [2:0] n);
    return n > 3'd4 ? CH_DASH : char_t'({2'b00, n});
  endfunction
endpackage

// File: rtl/bc_seg_decoder.sv
// bc_seg_decoder: character code to active-low {g,f,e,d,c,b,a} segment pattern.
module bc_seg_decoder import bc_display_pkg::*; (
  input  logic [4:0] ch_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (char_t'(ch_i))
      CH_0:     seg_o = SEG_0;
      CH_1:     seg_o = SEG_1;
      CH_2:     seg_o = SEG_2;
      CH_3:     seg_o = SEG_3;
      CH_4:     seg_o = SEG_4;
      CH_5:     seg_o = SEG_5;
      CH_6:     seg_o = SEG_6;
      CH_7:     seg_o = SEG_7;
      CH_8:     seg_o = SEG_8;
      CH_9:     seg_o = SEG_9;
      CH_A:     seg_o = SEG_A;
      CH_B:     seg_o = SEG_B;
      CH_C:     seg_o = SEG_C;
      CH_D:     seg_o = SEG_D;
      CH_E_HEX: seg_o = SEG_E;
      CH_F:     seg_o = SEG_F;
      CH_BL:    seg_o = SEG_B;
      CH_CU:    seg_o = SEG_C;
      CH_P:     seg_o = SEG_P;
      CH_DL:    seg_o = SEG_D;
      CH_O:     seg_o = SEG_O;
      CH_N:     seg_o = SEG_N;
      CH_E:     seg_o = SEG_E;
      CH_DASH:  seg_o = SEG_DASH;
      default:  seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bc_display_scan.sv
// bc_display_scan: scans an 8-character game frame onto eight 7-segment digits.
// Define BC_DISPLAY_BLINK_EN to blink the WIN frame every BLINK_TICKS refresh ticks.
module bc_display_scan import bc_display_pkg::*; #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [15:0] sw,
  input  logic [15:0] guess,
  input  logic [2:0]  bulls,
  input  logic [2:0]  cows,
  input  logic        player,
  input  logic        load,
  output logic [7:0]  an,
  output logic [6:0]  digit
);
  localparam int CW = $clog2(REFRESH_DIV);
  if (REFRESH_DIV < 2 || BLINK_TICKS < 1) begin : g_bad_params
    $error("bc_display_scan: REFRESH_DIV must be >= 2 and BLINK_TICKS >= 1");
  end
  mode_t         md;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   guess_q;
  logic [2:0]    bulls_q, cows_q;
  logic          player_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    digit_q, digit_d, seg;
  logic          tick, dark;
  char_t         frame [8];
  assign md    = mode_t'(mode);
  assign tick  = cnt_q == CW'(REFRESH_DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);
  assign idx_d = tick ? idx_q + 3'd1 : idx_q;
  always_comb begin
    frame = '{default: CH_BLANK};
    case (md)
      ENTRY: begin
        frame[7] = CH_P;
        frame[6] = player ? CH_2 : CH_1;
        for (int i = 0; i < 4; i++) frame[i] = char_t'({1'b0, sw[4*i +: 4]});
      end
      RESULT: begin
        frame[7] = count_char(bulls_q);
        frame[6] = CH_BL;
        frame[5] = count_char(cows_q);
        frame[4] = CH_CU;
        for (int i = 0; i < 4; i++) frame[i] = char_t'({1'b0, guess_q[4*i +: 4]});
      end
      WIN: begin
        frame[7] = CH_P;
        frame[6] = player_q ? CH_2 : CH_1;
        frame[4] = CH_DL;
        frame[3] = CH_O;
        frame[2] = CH_N;
        frame[1] = CH_E;
      end
      default: ;
    endcase
  end
  bc_seg_decoder u_dec (.ch_i(frame[idx_d]), .seg_o(seg));
`ifdef BC_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS) + 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d, bwrap;
  assign bwrap   = bcnt_q == BW'(BLINK_TICKS - 1);
  assign bcnt_d  = md != WIN ? '0 : tick ? (bwrap ? '0 : bcnt_q + BW'(1)) : bcnt_q;
  assign phase_d = md == WIN && (phase_q ^ (tick && bwrap));
  // The phase in effect before this tick decides the sample, so ticks BLINK_TICKS+1.. go dark.
  assign dark    = md == BLANK || phase_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  assign dark = md == BLANK;
`endif
  assign an_d    = tick ? (dark ? 8'hFF : ~(8'd1 << idx_d)) : an_q;
  assign digit_d = tick ? (dark ? 7'h7F : seg) : digit_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      an_q     <= 8'hFF;
      digit_q  <= 7'h7F;
      guess_q  <= 16'h0;
      bulls_q  <= 3'd0;
      cows_q   <= 3'd0;
      player_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      digit_q <= digit_d;
      if (load) begin
        guess_q  <= guess;
        bulls_q  <= bulls;
        cows_q   <= cows;
        player_q <= player;
      end
    end
  end
  assign an    = an_q;
  assign digit = digit_q;
endmodule

// File: tb/tb_bc_display_scan.sv
// tb_bc_display_scan: string-level frame model checked every cycle plus literal slot checks.
module tb_bc_display_scan;
  localparam int RD = 4;
  localparam int BT = 2;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [15:0] sw, guess;
  logic [2:0]  bulls, cows;
  logic        player, load;
  logic [7:0]  an;
  logic [6:0]  digit;
  int total = 0;
  int bad = 0;
  bc_display_scan #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .clock(clock), .reset(reset), .mode(mode), .sw(sw), .guess(guess),
    .bulls(bulls), .cows(cows), .player(player), .load(load), .an(an), .digit(digit)
  );
  always #5 clock = ~clock;
  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0": return 7'b1000000;
      "1": return 7'b1111001;
      "2": return 7'b0100100;
      "3": return 7'b0110000;
      "4": return 7'b0011001;
      "5": return 7'b0010010;
      "6": return 7'b0000010;
      "7": return 7'b1111000;
      "8": return 7'b0000000;
      "9": return 7'b0010000;
      "a", "A": return 7'b0001000;
      "b", "B": return 7'b0000011;
      "c", "C": return 7'b1000110;
      "d", "D": return 7'b0100001;
      "e", "E": return 7'b0000110;
      "f", "F": return 7'b0001110;
      "P": return 7'b0001100;
      "o": return 7'b0100011;
      "n": return 7'b0101011;
      "-": return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction
  function automatic string cnt_str(input logic [2:0] n);
    return n > 4 ? "-" : $sformatf("%0d", n);
  endfunction
  // Frame as text, leftmost character first.
  function automatic string frame_of(input logic [1:0] md, input logic [15:0] s, input logic pl_live,
                                     input logic [15:0] g, input logic [2:0] b, input logic [2:0] c,
                                     input logic pl);
    case (md)
      2'd0: return $sformatf("P%0d  %04h", int'(pl_live) + 1, s);
      2'd1: return {cnt_str(b), "b", cnt_str(c), "C", $sformatf("%04h", g)};
      2'd2: return $sformatf("P%0d donE ", int'(pl) + 1);
      default: return "        ";
    endcase
  endfunction
  int          m_cyc, m_ticks, m_slot, m_wt;
  logic [7:0]  m_an;
  logic [6:0]  m_dig;
  logic [15:0] m_g;
  logic [2:0]  m_b, m_c;
  logic        m_p;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_slot = 0; m_wt = 0; m_an = 8'hFF; m_dig = 7'h7F;
      m_g = 0; m_b = 0; m_c = 0; m_p = 0;
    end else begin
      bit    tk, dk;
      string f;
      tk = (m_cyc % RD) == RD - 1;
      m_wt = (mode != 2'd2) ? 0 : m_wt + (tk ? 1 : 0);
      if (tk) begin
        m_ticks++;
        m_slot = (m_slot + 1) % 8;
        dk = mode == 2'd3;
`ifdef BC_DISPLAY_BLINK_EN
        dk = dk || (mode == 2'd2 && ((m_wt - 1) / BT) % 2 == 1);
`endif
        f = frame_of(mode, sw, player, m_g, m_b, m_c, m_p);
        m_an  = dk ? 8'hFF : ~(8'd1 << m_slot);
        m_dig = dk ? 7'h7F : seg_of(f[7 - m_slot]);
      end
      if (load) begin
        m_g = guess; m_b = bulls; m_c = cows; m_p = player;
      end
      m_cyc++;
    end
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    if (!reset) begin
      chk("model_an", an, m_an);
      chk("model_digit", {1'b0, digit}, {1'b0, m_dig});
    end
  end
  task automatic see_slot(input int s, input string nm, input logic [6:0] exp);
    int t0;
    bit ok;
    t0 = m_ticks;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock);
      ok = m_ticks > t0 && m_slot == s;
    end
    if (!ok) chk({nm, "_timeout"}, 8'h00, 8'h01);
    else begin
      chk({nm, "_an"}, an, ~(8'd1 << s));
      chk(nm, {1'b0, digit}, {1'b0, exp});
    end
  endtask
  task automatic do_load(input logic [15:0] g, input logic [2:0] b, input logic [2:0] c, input logic p);
    @(negedge clock);
    guess = g; bulls = b; cows = c; player = p; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask
  initial begin
    reset = 1'b1; mode = 2'd0; sw = 16'h1234; guess = 0; bulls = 0; cows = 0; player = 1'b1; load = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_an", an, 8'hFF);
    chk("reset_digit", {1'b0, digit}, 8'h7F);
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      chk($sformatf("walk_an_%0d", i), an, i < 4 ? 8'hFF : ~(8'd1 << ((i / 4) % 8)));
      if (i == 24) chk("entry_slot6_2", {1'b0, digit}, 8'b00100100);
      if (i == 28) chk("entry_slot7_P", {1'b0, digit}, 8'b00001100);
      if (i == 32) chk("entry_slot0_4", {1'b0, digit}, 8'b00011001);
    end
    do_load(16'h5678, 3'd2, 3'd1, 1'b0);
    mode = 2'd1; guess = 16'hFFFF; bulls = 3'd7;
    see_slot(7, "result_bulls", 7'b0100100);
    see_slot(6, "result_b", 7'b0000011);
    see_slot(5, "result_cows", 7'b1111001);
    see_slot(4, "result_C", 7'b1000110);
    see_slot(0, "result_guess0", 7'b0000000);
    see_slot(3, "result_guess3", 7'b0010010);
    do_load(16'hABCD, 3'd6, 3'd4, 1'b0);
    see_slot(7, "result_dash", 7'b0111111);
    see_slot(5, "result_cows4", 7'b0011001);
    see_slot(1, "result_hexC", 7'b1000110);
    mode = 2'd2; player = 1'b1;
`ifndef BC_DISPLAY_BLINK_EN
    see_slot(7, "win_P", 7'b0001100);
    see_slot(6, "win_player", 7'b1111001);
    see_slot(5, "win_blank", 7'b1111111);
    see_slot(4, "win_d", 7'b0100001);
    see_slot(3, "win_o", 7'b0100011);
    see_slot(2, "win_n", 7'b0101011);
    see_slot(1, "win_E", 7'b0000110);
`else
    repeat (40) @(negedge clock);
`endif
    mode = 2'd3;
    repeat (5) @(negedge clock);
    chk("blank_an", an, 8'hFF);
    chk("blank_digit", {1'b0, digit}, 8'h7F);
    mode = 2'd0; sw = 16'h9F0E; player = 1'b0;
    repeat (40) @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset_an", an, 8'hFF);
    chk("midreset_digit", {1'b0, digit}, 8'h7F);
    mode = 2'd1; guess = 16'h4321;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk($sformatf("rerelease_an_%0d", i), an, i < 4 ? 8'hFF : 8'hFD);
    end
    see_slot(7, "cleared_bulls", 7'b1000000);
    see_slot(0, "cleared_guess", 7'b1000000);
    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
